// File: rtl/zapper_ctrl.sv
// zapper_ctrl: light-gun front end for the Duck Hunt display path.
// Debounces the raw trigger, then sequences black frame(s) followed by
// target-box frame(s), sampling the photodiode to decide hit or miss.
//
// Ports:
//   clk          pixel clock
//   reset_n      asynchronous active-low reset
//   trigger_n    raw trigger pin, active-low, asynchronous
//   light_in     photodiode comparator, active-high, asynchronous
//   frame_start  one-cycle pulse at the start of each frame (clk domain)
//   flash_black  request a full black frame from pattern_gen
//   flash_target request the white target box frame from pattern_gen
//   shot_fired   one-cycle pulse when a shot is accepted
//   hit / miss   one-cycle result pulses
//   busy         high whenever the FSM is not idle
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a debounced trigger press
// ARM     | shot accepted, waiting for the next frame boundary
// BLACK   | black frame(s) on screen, any light flags ambient
// TARGET  | target frame(s) on screen, counting light cycles
// RESULT  | one cycle, hit or miss pulse is high
// HOLDOFF | waiting for the trigger to be released
module zapper_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int BLACK_FRAMES    = 1,
    parameter int TARGET_FRAMES   = 1,
    parameter int LIGHT_MIN       = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic trigger_n,
    input  logic light_in,
    input  logic frame_start,
    output logic flash_black,
    output logic flash_target,
    output logic shot_fired,
    output logic hit,
    output logic miss,
    output logic busy
);

    localparam int DEB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LIGHT_W   = $clog2(LIGHT_MIN + 1);
    localparam int FRAME_MAX = (BLACK_FRAMES > TARGET_FRAMES) ? BLACK_FRAMES : TARGET_FRAMES;
    localparam int FRAME_W   = $clog2(FRAME_MAX + 1);

    localparam logic [DEB_W-1:0]   DEB_FULL    = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [LIGHT_W-1:0] LIGHT_FULL  = LIGHT_W'(LIGHT_MIN);
    localparam logic [FRAME_W-1:0] BLACK_DONE  = FRAME_W'(BLACK_FRAMES);
    localparam logic [FRAME_W-1:0] TARGET_DONE = FRAME_W'(TARGET_FRAMES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_BLACK,
        S_TARGET,
        S_RESULT,
        S_HOLDOFF
    } state_t;

    state_t state, state_nxt;

    logic trig_meta, trig_sync;
    logic light_meta, light_sync;
    logic [DEB_W-1:0]   deb_cnt;
    logic               pressed, pressed_q, press_evt;
    logic [FRAME_W-1:0] frame_cnt, frame_inc;
    logic [LIGHT_W-1:0] light_cnt, light_cnt_nxt;
    logic               ambient;
    logic               score_hit;

    // Trigger idles released (1), light idles dark (0).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_meta  <= 1'b1;
            trig_sync  <= 1'b1;
            light_meta <= 1'b0;
            light_sync <= 1'b0;
        end else begin
            trig_meta  <= trigger_n;
            trig_sync  <= trig_meta;
            light_meta <= light_in;
            light_sync <= light_meta;
        end
    end

    assign pressed   = (deb_cnt == DEB_FULL);
    assign press_evt = pressed & ~pressed_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_cnt   <= '0;
            pressed_q <= 1'b0;
        end else begin
            if (trig_sync)
                deb_cnt <= '0;
            else if (!pressed)
                deb_cnt <= deb_cnt + DEB_W'(1);
            pressed_q <= pressed;
        end
    end

    assign frame_inc     = frame_cnt + FRAME_W'(1);
    assign light_cnt_nxt = (light_sync && (light_cnt != LIGHT_FULL)) ?
                           light_cnt + LIGHT_W'(1) : light_cnt;
    // Includes this cycle's light so the final TARGET cycle still counts.
    assign score_hit     = (light_cnt_nxt == LIGHT_FULL) && !ambient;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (press_evt) state_nxt = S_ARM;
            S_ARM:     if (frame_start) state_nxt = S_BLACK;
            S_BLACK:   if (frame_start && (frame_inc == BLACK_DONE)) state_nxt = S_TARGET;
            S_TARGET:  if (frame_start && (frame_inc == TARGET_DONE)) state_nxt = S_RESULT;
            S_RESULT:  state_nxt = S_HOLDOFF;
            S_HOLDOFF: if (!pressed) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        flash_black  = (state == S_BLACK);
        flash_target = (state == S_TARGET);
        busy         = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt  <= '0;
            light_cnt  <= '0;
            ambient    <= 1'b0;
            shot_fired <= 1'b0;
            hit        <= 1'b0;
            miss       <= 1'b0;
        end else begin
            shot_fired <= (state == S_IDLE) && press_evt;
            hit        <= 1'b0;
            miss       <= 1'b0;
            case (state)
                S_ARM: begin
                    if (frame_start) begin
                        frame_cnt <= '0;
                        ambient   <= 1'b0;
                    end
                end
                S_BLACK: begin
                    if (light_sync)
                        ambient <= 1'b1;
                    if (state_nxt == S_TARGET) begin
                        frame_cnt <= '0;
                        light_cnt <= '0;
                    end else if (frame_start) begin
                        frame_cnt <= frame_inc;
                    end
                end
                S_TARGET: begin
                    light_cnt <= light_cnt_nxt;
                    if (frame_start)
                        frame_cnt <= frame_inc;
                    // Result pulse is registered on entry so it is high during RESULT.
                    if (state_nxt == S_RESULT) begin
                        hit  <= score_hit;
                        miss <= !score_hit;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_zapper_ctrl.sv
// Bench for zapper_ctrl: directed test-plan shots plus randomized shots,
// with expected timing and hit/miss derived from frame arithmetic.
module tb_zapper_ctrl;

    localparam int DEB     = 4;
    localparam int BF      = 1;
    localparam int TF      = 1;
    localparam int LMIN    = 3;
    localparam int FPERIOD = 100;

    logic clk;
    logic reset_n;
    logic trigger_n;
    logic light_in;
    logic frame_start;
    logic flash_black;
    logic flash_target;
    logic shot_fired;
    logic hit;
    logic miss;
    logic busy;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc_n = 0;
    int shot_cnt = 0, hit_cnt = 0, miss_cnt = 0, busy_cyc = 0;
    int wide_cnt = 0, overlap_cnt = 0;
    int fb_rise = -1, fb_fall = -1, ft_rise = -1, ft_fall = -1;
    int shot_cyc = -1, res_cyc = -1;
    bit p_fb = 0, p_ft = 0, p_shot = 0, p_hit = 0, p_miss = 0;

    zapper_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .BLACK_FRAMES   (BF),
        .TARGET_FRAMES  (TF),
        .LIGHT_MIN      (LMIN)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .trigger_n   (trigger_n),
        .light_in    (light_in),
        .frame_start (frame_start),
        .flash_black (flash_black),
        .flash_target(flash_target),
        .shot_fired  (shot_fired),
        .hit         (hit),
        .miss        (miss),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One cycle: sample outputs at the falling edge, then drive frame_start.
    task automatic cyc();
        @(negedge clk);
        cyc_n++;
        if (shot_fired) begin shot_cnt++; shot_cyc = cyc_n; end
        if (hit)  begin hit_cnt++;  res_cyc = cyc_n; end
        if (miss) begin miss_cnt++; res_cyc = cyc_n; end
        if ((shot_fired && p_shot) || (hit && p_hit) || (miss && p_miss)) wide_cnt++;
        if (flash_black && flash_target) overlap_cnt++;
        if (busy) busy_cyc++;
        if (flash_black && !p_fb && fb_rise < 0) fb_rise = cyc_n;
        if (!flash_black && p_fb && fb_fall < 0) fb_fall = cyc_n;
        if (flash_target && !p_ft && ft_rise < 0) ft_rise = cyc_n;
        if (!flash_target && p_ft && ft_fall < 0) ft_fall = cyc_n;
        p_fb = flash_black; p_ft = flash_target;
        p_shot = shot_fired; p_hit = hit; p_miss = miss;
        frame_start = ((cyc_n % FPERIOD) == 0);
    endtask

    // Full shot: press, light bursts at given offsets within the black
    // and target frames, hold through result, then release.
    task automatic do_shot(input string tag, input int bs, input int bl,
                           input int ts, input int tl);
        int press_cyc, exp_shot, exp_fb, s0, h0, m0, b0, rel;
        bit exp_hit;
        fb_rise = -1; fb_fall = -1; ft_rise = -1; ft_fall = -1;
        shot_cyc = -1; res_cyc = -1;
        s0 = shot_cnt; h0 = hit_cnt; m0 = miss_cnt;
        exp_hit = (bl == 0) && (tl >= LMIN);
        trigger_n = 1'b0;
        press_cyc = cyc_n;
        exp_shot  = press_cyc + 2 + DEB + 1;
        exp_fb    = ((exp_shot + FPERIOD - 1) / FPERIOD) * FPERIOD + 1;
        for (int i = 0; i < 500 && res_cyc < 0; i++) begin
            cyc();
            rel = (fb_rise < 0) ? -1000 : cyc_n - fb_rise;
            light_in = (rel >= bs && rel < bs + bl) ||
                       (rel >= BF*FPERIOD + ts && rel < BF*FPERIOD + ts + tl);
        end
        light_in = 1'b0;
        chk({tag, "_shot_count"}, shot_cnt - s0, 1);
        chk({tag, "_shot_latency"}, shot_cyc, exp_shot);
        chk({tag, "_black_rise"}, fb_rise, exp_fb);
        chk({tag, "_black_fall"}, fb_fall, exp_fb + BF*FPERIOD);
        chk({tag, "_target_rise"}, ft_rise, exp_fb + BF*FPERIOD);
        chk({tag, "_target_fall"}, ft_fall, exp_fb + (BF+TF)*FPERIOD);
        chk({tag, "_result_cycle"}, res_cyc, exp_fb + (BF+TF)*FPERIOD);
        chk({tag, "_hit"}, hit_cnt - h0, exp_hit ? 1 : 0);
        chk({tag, "_miss"}, miss_cnt - m0, exp_hit ? 0 : 1);
        b0 = busy_cyc;
        repeat (20) cyc();
        chk({tag, "_holdoff_busy"}, busy_cyc - b0, 20);
        chk({tag, "_holdoff_noshot"}, shot_cnt - s0, 1);
        trigger_n = 1'b1;
        repeat (10) cyc();
        chk({tag, "_released_idle"}, busy, 0);
    endtask

    initial begin
        int s0, h0, m0, b0, gap;
        reset_n = 1'b0; trigger_n = 1'b1; light_in = 1'b0; frame_start = 1'b0;
        repeat (3) cyc();
        chk("reset_outputs", {flash_black, flash_target, shot_fired, hit, miss, busy}, 0);
        reset_n = 1'b1;
        repeat (5) cyc();
        chk("idle_busy", busy, 0);

        // Bounce rejection: never DEB consecutive low cycles.
        s0 = shot_cnt; b0 = busy_cyc;
        trigger_n = 1'b0; repeat (3) cyc();
        trigger_n = 1'b1; cyc();
        trigger_n = 1'b0; repeat (3) cyc();
        trigger_n = 1'b1; repeat (12) cyc();
        chk("bounce_noshot", shot_cnt - s0, 0);
        chk("bounce_busy", busy_cyc - b0, 0);

        do_shot("clean_hit", 0, 0, 30, 5);
        do_shot("low_light", 0, 0, 30, 2);
        do_shot("exact_min", 0, 0, 40, 3);
        do_shot("ambient", 30, 1, 30, 10);

        // Press event lands on the same edge as a frame_start in IDLE.
        for (int i = 0; i < 200 && (cyc_n % FPERIOD) != FPERIOD - 6; i++) cyc();
        do_shot("same_cycle", 0, 0, 20, 4);

        for (int k = 0; k < 5; k++) begin
            gap = $urandom_range(0, 150);
            repeat (gap) cyc();
            do_shot("rand", $urandom_range(10, 60),
                    ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 3),
                    $urandom_range(10, 60), $urandom_range(0, 6));
        end

        // Reset in the middle of the target frame.
        trigger_n = 1'b0;
        for (int i = 0; i < 400 && !flash_target; i++) cyc();
        chk("rst_reached_target", flash_target, 1);
        light_in = 1'b1; repeat (5) cyc(); light_in = 1'b0;
        repeat (20) cyc();
        #2;
        reset_n = 1'b0; trigger_n = 1'b1;
        #1;
        chk("rst_async_outputs", {flash_black, flash_target, shot_fired, hit, miss, busy}, 0);
        repeat (3) cyc();
        reset_n = 1'b1;
        s0 = shot_cnt; h0 = hit_cnt; m0 = miss_cnt;
        repeat (300) cyc();
        chk("rst_no_hit", hit_cnt - h0, 0);
        chk("rst_no_miss", miss_cnt - m0, 0);
        chk("rst_no_shot", shot_cnt - s0, 0);
        chk("rst_busy", busy, 0);

        chk("pulse_width", wide_cnt, 0);
        chk("flash_overlap", overlap_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/zapper_ctrl.md
# zapper_ctrl

Light-gun front end for the Duck Hunt display path. It debounces the raw active-low trigger pin and sequences the shot-detection frames: one or more black frames, then one or more target-box frames. It samples the photodiode during those frames and reports hit or miss. It sits upstream of `pattern_gen`, which draws the black and target frames on request, and it takes frame timing from the `vga` frame-start pulse.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable-low cycles needed to accept a press (10 ms at 25 MHz). Must be ≥1.
- `BLACK_FRAMES`, default 1: number of all-black frames before the target frames. Must be ≥1.
- `TARGET_FRAMES`, default 1: number of frames with the target box lit. Must be ≥1.
- `LIGHT_MIN`, default 8: light-high cycles during the target frames needed to score a hit. Must be ≥1.

Ports:
- `clk` in 1: pixel clock (PLL output).
- `reset_n` in 1: asynchronous, active-low reset.
- `trigger_n` in 1: raw trigger pin, active-low, asynchronous.
- `light_in` in 1: photodiode comparator, active-high, asynchronous.
- `frame_start` in 1: one-cycle pulse at the start of each frame; synchronous to `clk`.
- `flash_black` out 1: request to `pattern_gen` to draw a full black frame.
- `flash_target` out 1: request to `pattern_gen` to draw the white target box on black.
- `shot_fired` out 1: one-cycle pulse when a shot is accepted.
- `hit` out 1: one-cycle pulse when the shot result is a hit.
- `miss` out 1: one-cycle pulse when the shot result is a miss.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **Synchronizers.** `trigger_n` and `light_in` each pass through a 2-FF synchronizer. On reset, the trigger synchronizer resets to 1 (released) and the light synchronizer resets to 0.
- **Debounce.**
  - The counter is $clog2(DEBOUNCE_CYCLES+1) bits wide.
  - It clears whenever the synchronized trigger is high.
  - While the trigger is low, it increments, saturating at DEBOUNCE_CYCLES.
  - `pressed` = (count == DEBOUNCE_CYCLES).
  - A press event is the rising edge of `pressed`.
- **FSM states:** IDLE, ARM, BLACK, TARGET, RESULT, HOLDOFF.
  - **IDLE:** a press event moves to ARM and pulses `shot_fired`.
  - **ARM:** wait for `frame_start`, then move to BLACK and clear the frame counter and the `ambient` flag.
  - **BLACK:** `flash_black`=1.
    - Any synchronized light high sets `ambient`.
    - Each `frame_start` increments the frame counter.
    - When the count reaches BLACK_FRAMES, move to TARGET and clear the frame counter and the light counter.
  - **TARGET:** `flash_target`=1.
    - Each cycle with synchronized light high increments the light counter, saturating at LIGHT_MIN; the counter is $clog2(LIGHT_MIN+1) bits wide.
    - Each `frame_start` increments the frame counter.
    - When the count reaches TARGET_FRAMES, move to RESULT.
  - **RESULT:** lasts exactly one cycle.
    - `hit`=1 if the light counter equals LIGHT_MIN and `ambient`=0; otherwise `miss`=1.
    - Then move to HOLDOFF.
  - **HOLDOFF:** wait until `pressed`=0 (trigger released and debounce cleared), then move to IDLE.
- **Retrigger and chaining.**
  - Press events outside IDLE are ignored.
  - Holding the trigger never fires a second shot.
- **Ambient light.** Light seen during the black frames forces a miss; this rejects aiming at a lamp.

## Timing
- **Reset values.** All outputs are 0 after reset. The state is IDLE and all counters are 0. Reset asserted mid-sequence drops `flash_black`/`flash_target` immediately (asynchronously) and no hit or miss is reported.
- **Outputs are registered.**
  - `flash_black`, `flash_target` and `busy` are decoded from the state register.
  - `shot_fired`, `hit` and `miss` are registered pulses, exactly one cycle wide.
- **Press latency.**
  - `pressed` rises DEBOUNCE_CYCLES cycles after the synchronized trigger first reads low.
  - `shot_fired` and `busy` rise on the next clock edge.
- **Frame alignment.**
  - `flash_black` rises the cycle after the first `frame_start` seen in ARM.
  - On the frame_start that completes the black frames, `flash_black` falls and `flash_target` rises in the same cycle.
  - `flash_target` falls, and `hit`/`miss` is asserted, the cycle after the frame_start that completes the target frames.
- **Same-cycle frame_start and press in IDLE.** That frame_start is not consumed; ARM waits for the next one.
- **Light counting window.** Light is counted on cycles while the state is TARGET. The count includes the 2-cycle synchronizer delay, with no compensation.

## Test plan
Use DEBOUNCE_CYCLES=4, BLACK_FRAMES=1, TARGET_FRAMES=1, LIGHT_MIN=3, with `frame_start` every 100 cycles.

- **Bounce rejection.** Drive `trigger_n` low for 3 cycles, high for 1, low for 3, then high → no `shot_fired`; `busy` stays 0.
- **Clean hit.** Hold `trigger_n` low. Keep `light_in`=0 during the black frame and drive it high for 5 cycles during the target frame → one `shot_fired`; `flash_black` lasts 100 cycles, then `flash_target` lasts 100 cycles; `hit`=1 for one cycle; `miss` stays 0.
- **Insufficient light.** Same stimulus with only 2 light-high cycles in the target frame → `miss`=1 for one cycle; `hit` stays 0.
- **Ambient reject.** Drive light high for 1 cycle during the black frame and 10 cycles during the target frame → `miss`=1.
- **Hold and retrigger.** Keep the trigger held through RESULT → FSM stays in HOLDOFF with `busy`=1. Release the trigger, then press again → exactly one new `shot_fired` per press.
- **Reset mid-TARGET.** Drop `reset_n` while `flash_target`=1 → all outputs are 0 immediately. After reset is released, no `hit`/`miss` appears and `busy`=0.
